count_bcd_display: RTL and testbench
====================================

Name: count_bcd_display

Overview:
Downstream consumer of the counter chain's count output on the DE1-SoC build. The block periodically samples the binary count and converts it to decimal with an iterative shift-add-3 (double-dabble) sequencer. It then drives active-low seven-segment digit patterns to the HEX pins. The sampled value stays stable on the display between samples, so a fast-running count is human-readable.

Parameters:
IN_WIDTH, 16, width of count_in (matches counter chain counterSize)
NUM_DIGITS, 5, number of decimal digits / seven-segment displays driven
SAMPLE_PERIOD, 50000000, clk cycles between samples (1 Hz at 50 MHz); must be > IN_WIDTH+2

Ports:
clk  input  1  system clock, all logic rising-edge
reset  input  1  asynchronous, active-low reset (0 = reset)
count_in  input  IN_WIDTH  binary count from counter chain outCount
hex_out  output  7*NUM_DIGITS  segment patterns; digit k (k=0 least significant) at [7k+6:7k]
busy  output  1  high while conversion in progress
valid  output  1  high once the first conversion has been displayed
overflow  output  1  last displayed value exceeded 10^NUM_DIGITS-1
overrun  output  1  sticky: sample tick arrived while busy

Behaviour:
- Reset (reset=0, asynchronous):
  - hex_out all digits 7'h7F (blank); busy=0, valid=0, overflow=0, overrun=0.
  - Timer=0, FSM=IDLE, capture/BCD registers=0.
- Segment encoding: bits {g,f,e,d,c,b,a}, bit0=a, active-low.
  - Digits 0-9 = 40,79,24,30,19,12,02,78,00,10 (hex).
  - Dash = 3F; blank = 7F.
- Sample timer:
  - Counts 0..SAMPLE_PERIOD-1 and wraps.
  - tick is asserted for one cycle when timer==SAMPLE_PERIOD-1, so the first tick occurs SAMPLE_PERIOD cycles after reset deasserts.
  - Runs continuously regardless of FSM state.
- FSM states:
  - IDLE: on tick, capture count_in into shift register, clear BCD register (NUM_DIGITS+1 digits, one guard digit), set iteration counter=0, go to SHIFT; busy=1 from the next cycle.
  - SHIFT: one iteration per cycle. Every BCD digit >=5 gets +3, then {bcd,shift} shifts left 1. After IN_WIDTH iterations go to DONE.
  - DONE: register hex_out from BCD digits 0..NUM_DIGITS-1. If the guard digit is nonzero, all digits = dash and overflow=1; else overflow=0. valid=1, busy=0, go to IDLE.
- Latency: hex_out reflects count_in as sampled at the tick edge, updated exactly IN_WIDTH+2 cycles after that tick.
- count_in changes during SHIFT/DONE have no effect; only the captured value is converted.
- Tick while state != IDLE:
  - The tick is ignored (no restart or queueing) and overrun is set to 1.
  - overrun stays set until reset.
- Value 0 displays as all digits 40 (see optional feature).
- hex_out holds its value between DONE updates; no glitching during SHIFT.
- Reset mid-SHIFT: immediate return to reset values; the partial conversion is discarded.
- Width rule: the guard digit catches values >= 10^NUM_DIGITS. This holds because IN_WIDTH <= 3.32*(NUM_DIGITS+1) for legal configs; illegal configs are rejected by a generate-time check.

Optional Feature:
Macro LEADING_ZERO_BLANK_EN.
- Defined: in DONE, the most-significant digits that are zero, down to but excluding digit 0, display blank (7F). Digit 0 always shows its value, e.g. 42 with 5 digits shows blank,blank,blank,4,2. Overflow dashes are unaffected.
- Undefined: all digits always displayed, with leading zeros (40).

Test Plan:
- Reset asserted mid-run, then released → hex_out all 7F, busy=0, valid=0, overflow=0, overrun=0; first tick SAMPLE_PERIOD cycles after release.
- SAMPLE_PERIOD=32, count_in=12345 at tick → 18 cycles later hex_out digits4..0 = 79,24,30,19,12; valid=1, busy=0 on the same cycle.
- count_in=65535, changed to 0 one cycle after the tick → display 02,12,12,30,12 (65535); the change is ignored.
- NUM_DIGITS=3, IN_WIDTH=10, count_in=1000 → all three digits 3F, overflow=1; next sample 999 → 10,10,10, overflow=0.
- SAMPLE_PERIOD=10 (< 18) → second tick lands in SHIFT: overrun=1 and stays 1; the display updates only from ticks that arrive in IDLE.
- LEADING_ZERO_BLANK_EN defined, count_in=0 → 7F,7F,7F,7F,40; count_in=42 → 7F,7F,7F,19,24.

Source files
------------

// File: rtl/count_bcd_display_if.sv
// Count/display bundle between the counter chain and the seven-segment display block.
// Latency: none, wires only.
// Backpressure: none; count_in is sampled by the display block on its own schedule.
//
// Signals:
//   count_in  binary count from the counter chain
//   hex_out   active-low segment patterns, digit k at [7k+6:7k]
//   busy      conversion in progress
//   valid     first conversion has been displayed
//   overflow  displayed value exceeded 10^NUM_DIGITS-1
//   overrun   sticky, a sample tick arrived while busy
interface count_bcd_display_if #(
  parameter int IN_WIDTH   = 16,
  parameter int NUM_DIGITS = 5
);
  logic [IN_WIDTH-1:0]     count_in;
  logic [7*NUM_DIGITS-1:0] hex_out;
  logic                    busy;
  logic                    valid;
  logic                    overflow;
  logic                    overrun;

  // Upstream side: supplies the count and watches the display status.
  modport master (
    output count_in,
    input  hex_out, busy, valid, overflow, overrun
  );

  // Display block side.
  modport slave (
    input  count_in,
    output hex_out, busy, valid, overflow, overrun
  );
endinterface

// File: rtl/count_bcd_display.sv
// Samples count_in every SAMPLE_PERIOD cycles, converts it to BCD by double-dabble, drives HEX.
// Latency: hex_out updates IN_WIDTH+2 cycles after the tick cycle that captured the count.
// Backpressure: none; a tick arriving mid-conversion is dropped and sets the sticky overrun flag.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset (0 = reset)
//   bus    count_bcd_display_if.slave: count_in in; hex_out, busy, valid, overflow, overrun out
//
// Optional build macro LEADING_ZERO_BLANK_EN: when defined, leading zero digits above digit 0
// are shown blank instead of as '0'. Overflow dashes are not affected.
module count_bcd_display #(
  parameter int IN_WIDTH      = 16,
  parameter int NUM_DIGITS    = 5,
  parameter int SAMPLE_PERIOD = 50000000
) (
  input  logic                clk,
  input  logic                reset,
  count_bcd_display_if.slave  bus
);

  // BCD register carries one guard digit above the displayed digits.
  localparam int BW = 4 * (NUM_DIGITS + 1);
  localparam int TW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int IW = $clog2(IN_WIDTH + 1);

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // The guard digit only catches every overflow if the input cannot exceed
  // NUM_DIGITS+1 decimal digits: IN_WIDTH <= 3.32*(NUM_DIGITS+1).
  if (IN_WIDTH * 100 > 332 * (NUM_DIGITS + 1)) begin : g_bad_cfg
    $error("count_bcd_display: IN_WIDTH too large for NUM_DIGITS+1 BCD digits");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic [IN_WIDTH-1:0]     shift_q, shift_d;
  logic [BW-1:0]           bcd_q, bcd_d;
  logic [IW-1:0]           iter_q, iter_d;
  logic [7*NUM_DIGITS-1:0] hex_q, hex_d;
  logic                    busy_q, busy_d;
  logic                    valid_q, valid_d;
  logic                    overflow_q, overflow_d;
  logic                    overrun_q, overrun_d;

  logic                    tick;
  logic [BW-1:0]           bcd_adj;
`ifdef LEADING_ZERO_BLANK_EN
  logic                    lead;
`endif

  // Active-low {g,f,e,d,c,b,a} pattern for one decimal digit.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  assign tick = (timer_q == TW'(SAMPLE_PERIOD - 1));

  // Double-dabble correction: any digit >= 5 gets +3 so the following
  // left shift carries correctly into the next decimal digit.
  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < NUM_DIGITS + 1; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) begin
        bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bcd_d      = bcd_q;
    iter_d     = iter_q;
    hex_d      = hex_q;
    busy_d     = busy_q;
    valid_d    = valid_q;
    overflow_d = overflow_q;
    overrun_d  = overrun_q;
`ifdef LEADING_ZERO_BLANK_EN
    lead       = 1'b1;
`endif

    // Free-running sample timer, independent of the sequencer.
    timer_d = tick ? '0 : timer_q + TW'(1);

    // Ticks are never queued; one that finds the sequencer busy is lost.
    if (tick && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (tick) begin
          shift_d = bus.count_in;
          bcd_d   = '0;
          iter_d  = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        {bcd_d, shift_d} = {bcd_adj[BW-2:0], shift_q, 1'b0};
        iter_d = iter_q + IW'(1);
        if (iter_q == IW'(IN_WIDTH - 1)) begin
          state_d = DONE;
        end
      end

      DONE: begin
        for (int k = 0; k < NUM_DIGITS; k++) begin
          hex_d[7*k +: 7] = seg7(bcd_q[4*k +: 4]);
        end
`ifdef LEADING_ZERO_BLANK_EN
        // Blank zeros from the top down until the first nonzero digit;
        // digit 0 is never blanked so a zero count still shows '0'.
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
          if (lead && (bcd_q[4*k +: 4] == 4'd0)) begin
            hex_d[7*k +: 7] = SEG_BLANK;
          end else begin
            lead = 1'b0;
          end
        end
`endif
        if (bcd_q[BW-1 -: 4] != 4'd0) begin
          hex_d      = {NUM_DIGITS{SEG_DASH}};
          overflow_d = 1'b1;
        end else begin
          overflow_d = 1'b0;
        end
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      shift_q    <= '0;
      bcd_q      <= '0;
      iter_q     <= '0;
      hex_q      <= {NUM_DIGITS{SEG_BLANK}};
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      shift_q    <= shift_d;
      bcd_q      <= bcd_d;
      iter_q     <= iter_d;
      hex_q      <= hex_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
      overrun_q  <= overrun_d;
    end
  end

  assign bus.hex_out  = hex_q;
  assign bus.busy     = busy_q;
  assign bus.valid    = valid_q;
  assign bus.overflow = overflow_q;
  assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_count_bcd_display.sv
// Directed bench for count_bcd_display: three instances with different
// parameter sets share one clock and reset and run on one timeline.
// All cycle numbers count rising edges after the most recent reset release.
module tb_count_bcd_display;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // a: 16-bit, 5 digits, period 32 (main function)
  // b: 10-bit, 3 digits, period 32 (overflow)
  // c: 16-bit, 5 digits, period 10 (ticks land mid-conversion)
  count_bcd_display_if #(.IN_WIDTH(16), .NUM_DIGITS(5)) if_a ();
  count_bcd_display_if #(.IN_WIDTH(10), .NUM_DIGITS(3)) if_b ();
  count_bcd_display_if #(.IN_WIDTH(16), .NUM_DIGITS(5)) if_c ();

  count_bcd_display #(.IN_WIDTH(16), .NUM_DIGITS(5), .SAMPLE_PERIOD(32)) u_a (
    .clk(clk), .reset(rst_n), .bus(if_a));
  count_bcd_display #(.IN_WIDTH(10), .NUM_DIGITS(3), .SAMPLE_PERIOD(32)) u_b (
    .clk(clk), .reset(rst_n), .bus(if_b));
  count_bcd_display #(.IN_WIDTH(16), .NUM_DIGITS(5), .SAMPLE_PERIOD(10)) u_c (
    .clk(clk), .reset(rst_n), .bus(if_c));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  localparam logic [34:0] H5_BLANK = {5{7'h7F}};
  localparam logic [20:0] H3_BLANK = {3{7'h7F}};
  localparam logic [34:0] H5_12345 = {7'h79, 7'h24, 7'h30, 7'h19, 7'h12};
  localparam logic [34:0] H5_65535 = {7'h02, 7'h12, 7'h12, 7'h30, 7'h12};
  localparam logic [20:0] H3_DASH  = {3{7'h3F}};
  localparam logic [20:0] H3_999   = {3{7'h10}};
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [34:0] H5_7     = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h78};
  localparam logic [34:0] H5_250   = {7'h7F, 7'h7F, 7'h24, 7'h12, 7'h40};
  localparam logic [34:0] H5_0     = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40};
  localparam logic [34:0] H5_42    = {7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24};
`else
  localparam logic [34:0] H5_7     = {7'h40, 7'h40, 7'h40, 7'h40, 7'h78};
  localparam logic [34:0] H5_250   = {7'h40, 7'h40, 7'h24, 7'h12, 7'h40};
  localparam logic [34:0] H5_0     = {5{7'h40}};
  localparam logic [34:0] H5_42    = {7'h40, 7'h40, 7'h40, 7'h19, 7'h24};
`endif

  // Advance to 1 time unit after rising edge n (n counted from reset release).
  task automatic goto_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      cyc++;
    end
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
  endtask

  // Status nibble order below is {busy, valid, overflow, overrun}.
  task automatic test_reset();
    if_a.count_in = 16'd12345;
    if_b.count_in = 10'd1000;
    if_c.count_in = 16'd7;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({if_a.hex_out, if_b.hex_out, if_c.hex_out} !== {H5_BLANK, H3_BLANK, H5_BLANK}) begin
      n_fail++;
      $display("FAIL reset_hex: got %h %h %h, want all 7F", if_a.hex_out, if_b.hex_out, if_c.hex_out);
    end
    n_checks++;
    if ({if_a.busy, if_a.valid, if_a.overflow, if_a.overrun} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_status_a: got %b want 0000", {if_a.busy, if_a.valid, if_a.overflow, if_a.overrun});
    end
    release_reset();
    goto_cyc(40);
    n_checks++;
    if ({if_a.busy, if_a.valid, if_a.overflow, if_a.overrun} !== 4'b1000) begin
      n_fail++;
      $display("FAIL midrun_status_a: got %b want 1000", {if_a.busy, if_a.valid, if_a.overflow, if_a.overrun});
    end
    n_checks++;
    if ({if_c.busy, if_c.valid, if_c.overflow, if_c.overrun} !== 4'b1101) begin
      n_fail++;
      $display("FAIL midrun_status_c: got %b want 1101", {if_c.busy, if_c.valid, if_c.overflow, if_c.overrun});
    end
    // Asynchronous assertion between clock edges must clear everything at once.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({if_a.hex_out, if_b.hex_out, if_c.hex_out} !== {H5_BLANK, H3_BLANK, H5_BLANK}) begin
      n_fail++;
      $display("FAIL async_reset_hex: got %h %h %h, want all 7F", if_a.hex_out, if_b.hex_out, if_c.hex_out);
    end
    n_checks++;
    if ({if_a.busy, if_a.valid, if_a.overflow, if_a.overrun,
         if_b.busy, if_b.valid, if_b.overflow, if_b.overrun,
         if_c.busy, if_c.valid, if_c.overflow, if_c.overrun} !== 12'h000) begin
      n_fail++;
      $display("FAIL async_reset_status: got %b%b%b%b %b%b%b%b %b%b%b%b want all 0",
               if_a.busy, if_a.valid, if_a.overflow, if_a.overrun,
               if_b.busy, if_b.valid, if_b.overflow, if_b.overrun,
               if_c.busy, if_c.valid, if_c.overflow, if_c.overrun);
    end
    repeat (2) @(posedge clk);
    release_reset();
  endtask

  // c: capture at edge 10 (value 7), tick at cycle 19 hits SHIFT.
  task automatic test_overrun();
    goto_cyc(15);
    if_c.count_in = 16'd250;
    goto_cyc(19);
    n_checks++;
    if ({if_c.busy, if_c.valid, if_c.overflow, if_c.overrun} !== 4'b1000) begin
      n_fail++;
      $display("FAIL overrun_before: got %b want 1000", {if_c.busy, if_c.valid, if_c.overflow, if_c.overrun});
    end
    goto_cyc(20);
    n_checks++;
    if ({if_c.busy, if_c.valid, if_c.overflow, if_c.overrun} !== 4'b1001) begin
      n_fail++;
      $display("FAIL overrun_set: got %b want 1001", {if_c.busy, if_c.valid, if_c.overflow, if_c.overrun});
    end
    goto_cyc(26);
    n_checks++;
    if (if_c.hex_out !== H5_BLANK) begin
      n_fail++;
      $display("FAIL c_hex_before_done: got %h want %h", if_c.hex_out, H5_BLANK);
    end
    goto_cyc(27);
    n_checks++;
    if (if_c.hex_out !== H5_7) begin
      n_fail++;
      $display("FAIL c_hex_7: got %h want %h", if_c.hex_out, H5_7);
    end
    n_checks++;
    if ({if_c.busy, if_c.valid, if_c.overflow, if_c.overrun} !== 4'b0101) begin
      n_fail++;
      $display("FAIL c_status_done: got %b want 0101", {if_c.busy, if_c.valid, if_c.overflow, if_c.overrun});
    end
  endtask

  // a: first tick in cycle 31, so busy rises after edge 32 and not earlier.
  task automatic test_first_tick();
    goto_cyc(31);
    n_checks++;
    if ({if_a.busy, if_a.valid, if_a.overflow, if_a.overrun} !== 4'b0000) begin
      n_fail++;
      $display("FAIL a_before_tick: got %b want 0000", {if_a.busy, if_a.valid, if_a.overflow, if_a.overrun});
    end
    goto_cyc(32);
    n_checks++;
    if ({if_a.busy, if_a.valid, if_a.overflow, if_a.overrun} !== 4'b1000) begin
      n_fail++;
      $display("FAIL a_busy_after_tick: got %b want 1000", {if_a.busy, if_a.valid, if_a.overflow, if_a.overrun});
    end
  endtask

  // c: the dropped tick must not restart; 250 appears only via the tick in cycle 29.
  task automatic test_overrun_ignored();
    goto_cyc(37);
    n_checks++;
    if (if_c.hex_out !== H5_7) begin
      n_fail++;
      $display("FAIL c_no_restart: got %h want %h", if_c.hex_out, H5_7);
    end
    n_checks++;
    if ({if_c.busy, if_c.valid, if_c.overflow, if_c.overrun} !== 4'b1101) begin
      n_fail++;
      $display("FAIL c_status_mid: got %b want 1101", {if_c.busy, if_c.valid, if_c.overflow, if_c.overrun});
    end
    goto_cyc(47);
    n_checks++;
    if (if_c.hex_out !== H5_250) begin
      n_fail++;
      $display("FAIL c_hex_250: got %h want %h", if_c.hex_out, H5_250);
    end
    n_checks++;
    if (if_c.overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL c_overrun_sticky: got %b want 1", if_c.overrun);
    end
  endtask

  // a: result 18 cycles after the tick cycle (31 -> 49); b: 1000 overflows 3 digits.
  task automatic test_conversion();
    goto_cyc(48);
    n_checks++;
    if (if_a.hex_out !== H5_BLANK || if_a.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL a_latency_early: got hex %h valid %b want %h valid 0", if_a.hex_out, if_a.valid, H5_BLANK);
    end
    goto_cyc(49);
    n_checks++;
    if (if_a.hex_out !== H5_12345) begin
      n_fail++;
      $display("FAIL a_hex_12345: got %h want %h", if_a.hex_out, H5_12345);
    end
    n_checks++;
    if ({if_a.busy, if_a.valid, if_a.overflow, if_a.overrun} !== 4'b0100) begin
      n_fail++;
      $display("FAIL a_status_12345: got %b want 0100", {if_a.busy, if_a.valid, if_a.overflow, if_a.overrun});
    end
    n_checks++;
    if (if_b.hex_out !== H3_DASH) begin
      n_fail++;
      $display("FAIL b_hex_1000: got %h want %h", if_b.hex_out, H3_DASH);
    end
    n_checks++;
    if ({if_b.busy, if_b.valid, if_b.overflow, if_b.overrun} !== 4'b0110) begin
      n_fail++;
      $display("FAIL b_status_1000: got %b want 0110", {if_b.busy, if_b.valid, if_b.overflow, if_b.overrun});
    end
  endtask

  // a: 65535 captured at edge 64 and replaced by 0 right after; b: 999 clears overflow.
  task automatic test_capture_ignore();
    if_a.count_in = 16'd65535;
    if_b.count_in = 10'd999;
    goto_cyc(64);
    if_a.count_in = 16'd0;
    if_b.count_in = 10'd0;
    goto_cyc(80);
    n_checks++;
    if (if_a.hex_out !== H5_12345) begin
      n_fail++;
      $display("FAIL a_hold_during_shift: got %h want %h", if_a.hex_out, H5_12345);
    end
    n_checks++;
    if ({if_a.busy, if_a.valid} !== 2'b11) begin
      n_fail++;
      $display("FAIL a_busy_valid_mid: got %b want 11", {if_a.busy, if_a.valid});
    end
    goto_cyc(81);
    n_checks++;
    if (if_a.hex_out !== H5_65535) begin
      n_fail++;
      $display("FAIL a_hex_65535: got %h want %h", if_a.hex_out, H5_65535);
    end
    n_checks++;
    if (if_b.hex_out !== H3_999) begin
      n_fail++;
      $display("FAIL b_hex_999: got %h want %h", if_b.hex_out, H3_999);
    end
    n_checks++;
    if ({if_b.busy, if_b.valid, if_b.overflow, if_b.overrun} !== 4'b0100) begin
      n_fail++;
      $display("FAIL b_status_999: got %b want 0100", {if_b.busy, if_b.valid, if_b.overflow, if_b.overrun});
    end
  endtask

  // a: 0 captured at edge 96, 42 captured at edge 128.
  task automatic test_leading_zeros();
    goto_cyc(113);
    n_checks++;
    if (if_a.hex_out !== H5_0) begin
      n_fail++;
      $display("FAIL a_hex_0: got %h want %h", if_a.hex_out, H5_0);
    end
    if_a.count_in = 16'd42;
    goto_cyc(145);
    n_checks++;
    if (if_a.hex_out !== H5_42) begin
      n_fail++;
      $display("FAIL a_hex_42: got %h want %h", if_a.hex_out, H5_42);
    end
    n_checks++;
    if ({if_a.busy, if_a.valid, if_a.overflow, if_a.overrun} !== 4'b0100) begin
      n_fail++;
      $display("FAIL a_status_42: got %b want 0100", {if_a.busy, if_a.valid, if_a.overflow, if_a.overrun});
    end
  endtask

  initial begin
    if_a.count_in = '0;
    if_b.count_in = '0;
    if_c.count_in = '0;
    test_reset();
    test_overrun();
    test_first_tick();
    test_overrun_ignored();
    test_conversion();
    test_capture_ignore();
    test_leading_zeros();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
